// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared types and constants for the data-memory arbiter.
//   state_t  : sequencer states IDLE / ACCESS / RESP
//   mst_id_t : requester id (0 = CPU data port, 1 = loader/debug port)
//   BE_W     : byte-enable width for the default word size
//   WORD_OFF : number of byte-offset bits dropped to form a word address
package dm_arbiter_pkg;

  localparam int DM_ADDR_W = 32;
  localparam int DM_DATA_W = 32;
  localparam int BE_W      = DM_DATA_W / 8;
  localparam int WORD_OFF  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic mst_id_t;

endpackage

// File: rtl/dm_byte_merge.sv
// dm_byte_merge: purely combinational byte-lane merge.
//   old_word : word currently held in memory
//   new_word : byte-lane aligned write data
//   be       : byte enables, lane i takes new_word when be[i] = 1
//   merged   : resulting word
// Shared by the store path of the arbiter and a later byte-load path.
module dm_byte_merge
  import dm_arbiter_pkg::*;
#(
  parameter int DATA_W = DM_DATA_W
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  // select each byte lane from the new or the old word
  always_comb begin
    merged = old_word;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester round-robin arbiter and IDLE/ACCESS/RESP
// sequencer in front of a word-only, single-ported data memory.
//   clk, reset            : clock, synchronous active-high reset
//   m0_* (CPU data port)  : req/we/addr/wdata/be/pc in; gnt/rvalid/rdata out
//   m1_* (loader/debug)   : same set as m0_*
//   mem_addr/mem_we/mem_wd: memory address, write enable, write data
//   mem_rd                : memory combinational read data
// Byte-enable stores are done as read-merge-write inside the single ACCESS
// cycle, using the memory's combinational read word.
// Optional macro DM_ARBITER_TRACE_EN prints every committed memory write.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [31:0]         m0_pc,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [31:0]         m1_pc,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wd,
  input  logic [DATA_W-1:0]   mem_rd
);

  localparam int NBE = DATA_W / 8;

  state_t              state;
  state_t              state_nxt;
  mst_id_t             ptr;
  mst_id_t             ptr_nxt;
  logic                gnt_any;
  mst_id_t             gnt_id;

  mst_id_t             lat_mst;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [NBE-1:0]      lat_be;
  logic [31:0]         lat_pc;

  logic [DATA_W-1:0]   merged;
  logic                unused_trace;

  // grant decision; the pointer only moves when both requesters contend
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    ptr_nxt = ptr;
    if (!reset && (state == IDLE || state == RESP)) begin
      if (m0_req && m1_req) begin
        gnt_any = 1'b1;
        gnt_id  = ptr;
        ptr_nxt = ~ptr;
      end else if (m0_req) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (m1_req) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end else begin
        gnt_any = 1'b0;
      end
    end else begin
      gnt_any = 1'b0;
    end
  end

  assign m0_gnt = gnt_any && (gnt_id == 1'b0);
  assign m1_gnt = gnt_any && (gnt_id == 1'b1);

  // sequencer next-state logic
  always_comb begin
    state_nxt = state;
    if (reset) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = gnt_any ? ACCESS : IDLE;
        ACCESS:  state_nxt = RESP;
        RESP:    state_nxt = gnt_any ? ACCESS : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // state and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // capture the winner's request on the grant edge
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_mst   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_pc    <= 32'h0000_0000;
    end else if (gnt_any) begin
      lat_mst   <= gnt_id;
      lat_we    <= gnt_id ? m1_we    : m0_we;
      lat_addr  <= gnt_id ? m1_addr  : m0_addr;
      lat_wdata <= gnt_id ? m1_wdata : m0_wdata;
      lat_be    <= gnt_id ? m1_be    : m0_be;
      lat_pc    <= gnt_id ? m1_pc    : m0_pc;
    end
  end

  dm_byte_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .old_word (mem_rd),
    .new_word (lat_wdata),
    .be       (lat_be),
    .merged   (merged)
  );

  // memory drive only during a non-reset ACCESS cycle
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    if (state == ACCESS && !reset) begin
      mem_addr = {lat_addr[ADDR_W-1:WORD_OFF], {WORD_OFF{1'b0}}};
      mem_we   = lat_we && (lat_be != '0);
      mem_wd   = merged;
    end else begin
      mem_we   = 1'b0;
    end
  end

  // response word: stores return the merged word, loads the raw read word
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (state == ACCESS) begin
      if (lat_mst == 1'b0) begin
        m0_rdata <= lat_we ? merged : mem_rd;
      end else begin
        m1_rdata <= lat_we ? merged : mem_rd;
      end
    end
  end

  assign m0_rvalid = (state == RESP) && !reset && (lat_mst == 1'b0);
  assign m1_rvalid = (state == RESP) && !reset && (lat_mst == 1'b1);

  // the pc and the byte-offset bits are only consumed by the trace
  assign unused_trace = ^{lat_pc, lat_addr[WORD_OFF-1:0]};

`ifdef DM_ARBITER_TRACE_EN
  // log each committed memory write with the issuing pc
  always_ff @(posedge clk) begin
    if (mem_we) begin
      $display("@%h: *%h <= %h", lat_pc, lat_addr, mem_wd);
    end
  end
`else
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized self-checking bench for dm_arbiter with a
// transaction-level reference model (cycle-stamped access/response slots and
// a shadow memory array).
module tb_dm_arbiter;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
    bit          keep;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_pc, m1_rdata;
  logic [3:0]  m1_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_pc(m0_pc), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_pc(m1_pc), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  // environment memory: 64 words, combinational read, posedge write
  logic [31:0] env_mem [64];
  bit          mem_loaded = 1'b0;
  assign mem_rd = env_mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= pat(i);
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      env_mem[mem_addr[7:2]] <= mem_wd;
    end
  end

  // reference model state
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          free_cyc = 0;
  bit          ptr_m = 1'b0;
  txn_t        pend [2];
  bit          pend_v [2];
  txn_t        q0 [$];
  txn_t        q1 [$];
  bit          acc_v = 1'b0;
  int          acc_cyc = 0;
  txn_t        acc;
  bit          acc_m = 1'b0;
  bit          rsp_v = 1'b0;
  int          rsp_cyc = 0;
  bit          rsp_m = 1'b0;
  logic [31:0] e_rdata [2];
  logic [31:0] ref_mem [64];
  int          rst_cnt = 0;
  bit          arm_rst = 1'b0;
  bit          auto_rand = 1'b0;
  bit          rec = 1'b0;
  int          gseq [$];
  int          gcyc [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic txn_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] pc, input bit keep);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.be = be; t.pc = pc; t.keep = keep;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)), $urandom, 1'b0);
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] nw, input logic [31:0] ow,
                                            input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (nw & mask) | (ow & ~mask);
  endfunction

  task automatic refill(input int m);
    if (pend_v[m] && !pend[m].keep && $urandom_range(7) == 0) pend_v[m] = 1'b0;
    if (!pend_v[m]) begin
      if (m == 0 && q0.size() > 0) begin
        pend[0] = q0.pop_front(); pend_v[0] = 1'b1;
      end else if (m == 1 && q1.size() > 0) begin
        pend[1] = q1.pop_front(); pend_v[1] = 1'b1;
      end else if (auto_rand && $urandom_range(2) == 0) begin
        pend[m] = rand_txn(); pend_v[m] = 1'b1;
      end
    end
  endtask

  task automatic model_step();
    bit gv, w, ax, rv, e_we;
    logic [31:0] old_w, mrg, e_addr, e_wd;
    int idx;
    gv = 1'b0; w = 1'b0; ax = 1'b0; rv = 1'b0; e_we = 1'b0;
    old_w = 32'h0; mrg = 32'h0; e_addr = 32'h0; e_wd = 32'h0; idx = 0;
    if (!reset && cyc >= free_cyc) begin
      if (pend_v[0] && pend_v[1]) begin gv = 1'b1; w = ptr_m; end
      else if (pend_v[0])         begin gv = 1'b1; w = 1'b0;  end
      else if (pend_v[1])         begin gv = 1'b1; w = 1'b1;  end
    end
    if (acc_v && acc_cyc == cyc && !reset) begin
      ax     = 1'b1;
      idx    = int'(acc.addr[7:2]);
      old_w  = ref_mem[idx];
      mrg    = ref_merge(acc.wdata, old_w, acc.be);
      e_we   = acc.we && (acc.be != 4'h0);
      e_addr = {acc.addr[31:2], 2'b00};
      e_wd   = mrg;
    end
    rv = rsp_v && rsp_cyc == cyc && !reset;
    check("m0_gnt", 32'(m0_gnt), 32'(gv && !w));
    check("m1_gnt", 32'(m1_gnt), 32'(gv && w));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", mem_addr, e_addr);
    check("mem_wd", mem_wd, e_wd);
    check("m0_rvalid", 32'(m0_rvalid), 32'(rv && !rsp_m));
    check("m1_rvalid", 32'(m1_rvalid), 32'(rv && rsp_m));
    check("m0_rdata", m0_rdata, e_rdata[0]);
    check("m1_rdata", m1_rdata, e_rdata[1]);
    if (rec && m0_gnt) begin gseq.push_back(0); gcyc.push_back(cyc); end
    if (rec && m1_gnt) begin gseq.push_back(1); gcyc.push_back(cyc); end
    if (reset) begin
      ptr_m = 1'b0; acc_v = 1'b0; rsp_v = 1'b0;
      e_rdata[0] = 32'h0; e_rdata[1] = 32'h0;
      free_cyc = cyc + 1;
    end else begin
      if (rsp_v && rsp_cyc == cyc) rsp_v = 1'b0;
      if (ax) begin
        if (e_we) ref_mem[idx] = mrg;
        e_rdata[acc_m] = acc.we ? mrg : old_w;
        rsp_v = 1'b1; rsp_cyc = cyc + 1; rsp_m = acc_m; acc_v = 1'b0;
      end
      if (gv) begin
        if (pend_v[0] && pend_v[1]) ptr_m = ~ptr_m;
        acc = pend[w]; acc_m = w; acc_v = 1'b1;
        acc_cyc = cyc + 1; free_cyc = cyc + 2;
        pend_v[w] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input bit rnd_rst);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rst_cnt > 0) begin
        reset = 1'b1; rst_cnt--;
      end else if (arm_rst && acc_v && acc_cyc == cyc) begin
        reset = 1'b1; arm_rst = 1'b0;
      end else if (rnd_rst && $urandom_range(99) == 0) begin
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
      refill(0);
      refill(1);
      m0_req = pend_v[0]; m0_we = pend[0].we; m0_addr = pend[0].addr;
      m0_wdata = pend[0].wdata; m0_be = pend[0].be; m0_pc = pend[0].pc;
      m1_req = pend_v[1]; m1_we = pend[1].we; m1_addr = pend[1].addr;
      m1_wdata = pend[1].wdata; m1_be = pend[1].be; m1_pc = pend[1].pc;
      @(negedge clk);
      model_step();
    end
  endtask

  logic [31:0] saved_30;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    e_rdata[0] = 32'h0; e_rdata[1] = 32'h0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = mk(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
      pend_v[m] = 1'b0;
    end
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_be = 4'h0; m0_pc = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_be = 4'h0; m1_pc = 32'h0;

    // reset with request lines toggling
    rst_cnt = 5; auto_rand = 1'b1;
    run(5, 1'b0);

    // first grant after reset with both requesting goes to m0
    auto_rand = 1'b0; pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    q0.push_back(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_3000, 1'b1));
    q1.push_back(mk(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_4000, 1'b1));
    run(1, 1'b0);
    check("first_gnt_m0", 32'(m0_gnt), 32'h1);
    check("first_gnt_m1", 32'(m1_gnt), 32'h0);

    // full-word write/read and a single-byte merge
    q0.push_back(mk(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0000_3004, 1'b1));
    q1.push_back(mk(1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 32'h0000_4004, 1'b1));
    q1.push_back(mk(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h0000_4008, 1'b1));
    run(20, 1'b0);
    check("m0_read_0x10", m0_rdata, 32'hDEAD_BEEF);
    check("m1_read_0x20", m1_rdata, 32'h1122_AB44);

    // continuous contention: grants alternate, one every 2 cycles
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'(i % 2), 32'h40 + 32'(i * 4), $urandom, 4'hF, 32'h100, 1'b1));
      q1.push_back(mk(1'(i % 2), 32'h80 + 32'(i * 4), $urandom, 4'hF, 32'h200, 1'b1));
    end
    rec = 1'b1;
    run(24, 1'b0);
    rec = 1'b0;
    check("contention_grants", 32'(gseq.size()), 32'd8);
    for (int i = 1; i < gseq.size(); i++) begin
      check("alternate", 32'(gseq[i]), 32'(gseq[i-1] == 0 ? 1 : 0));
      check("spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd2);
    end

    // reset during ACCESS of a write to 0x30
    saved_30 = env_mem[12];
    q0.push_back(mk(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 32'h0000_5000, 1'b1));
    arm_rst = 1'b1;
    run(8, 1'b0);
    check("rst_fired", 32'(arm_rst), 32'h0);
    check("rst_word_0x30", env_mem[12], saved_30);

    // randomized traffic with withdrawals and occasional resets
    auto_rand = 1'b1;
    run(400, 1'b1);
    auto_rand = 1'b0;
    run(10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-ported, word-addressed data memory: combinational read, write on posedge when WE is high.
- Requester 0 is the CPU data port; requester 1 is the loader/debug port.
- Grants the memory round-robin and runs each access through a fixed IDLE/ACCESS/RESP sequence.
- Adds byte-enable writes by merging into the memory's combinational read word, so the memory itself stays word-only.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  requester 0 request; held high until m0_gnt is seen.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- m0_wdata  in  DATA_W  write data, byte-lane aligned.
- m0_be  in  DATA_W/8  byte enables; ignored on reads.
- m0_pc  in  32  PC of the issuing instruction, for trace.
- m0_gnt  out  1  combinational pulse; the request is latched on this edge.
- m0_rvalid  out  1  one-cycle response pulse.
- m0_rdata  out  DATA_W  response word.
- m1_*  (same set as m0_*)  requester 1.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory combinational read data.

Behaviour:
- Reset values: state IDLE, priority pointer = 0 (m0), latched request = 0, rdata regs = 0. All gnt, rvalid, mem_we = 0; mem_addr = 0; mem_wd = 0.
- Grant decision is made in IDLE or RESP, and only while reset is low.
  - Only one requester active: that one is granted.
  - Both active: the requester named by the priority pointer is granted; the pointer then flips to the other requester.
  - Pointer is unchanged when there is no grant.
- On a grant edge: we, addr, wdata, be and pc are latched together with the master id; next state is ACCESS.
- No grant from IDLE: stay in IDLE. No grant from RESP: go to IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr = {latched addr[ADDR_W-1:2], 2'b00}.
  - mem_wd = per-byte merge: lane i takes wdata when be[i]=1, otherwise mem_rd lane i.
  - mem_we = latched we AND (be != 0) AND NOT reset.
  - The merged word (writes) or mem_rd (reads) is registered into the winner's rdata register at the end of the cycle.
  - Next state is RESP.
- RESP (exactly 1 cycle):
  - The winner's rvalid = 1 and its rdata holds the registered word; the other requester's rvalid = 0.
  - A new grant may be issued in the same cycle, so back-to-back throughput is one access per 2 cycles.
- Latency: grant edge -> rvalid 2 cycles later.
- rdata holds its value until that requester's next response.
- Write with be = 0: no memory write; still returns a response carrying the unmodified word.
- Outside ACCESS: mem_addr = 0, mem_we = 0, mem_wd = 0.
- Reset high in any state: next state IDLE, in-flight access dropped with no rvalid. mem_we is forced 0 in that same cycle, so no partial write.
- Deasserting a request before its grant is legal; nothing is latched.

Optional Feature:
- Macro DM_ARBITER_TRACE_EN.
- Defined: on every posedge in ACCESS where mem_we = 1, print "@%h: *%h <= %h" with the latched pc, the full latched addr and mem_wd. Printed for both requesters.
- Undefined: no display statements are compiled. RTL behaviour is identical with and without the macro.

Decomposition:
- Package dm_arbiter_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - master-id type (1 bit);
  - constants BE_W = DATA_W/8 and WORD_OFF = 2.
- Sub-module dm_byte_merge: purely combinational (old word, new word, be) -> merged word. It is also reused by a future byte-load path.

Test Plan:
- Reset with req lines toggling -> all outputs 0; first grant after reset goes to m0 when both request.
- m0 write 0x10, 0xDEADBEEF, be=4'hF, then m0 read 0x10 -> mem_we high in exactly one cycle; read rvalid 2 cycles after grant with rdata = 0xDEADBEEF.
- Word 0x20 holds 0x11223344; m1 write 0x0000AB00 with be=4'b0010 -> mem_wd = 0x1122AB44; a following read returns 0x1122AB44.
- m0 and m1 both requesting continuously for 8 accesses -> grants alternate m0,m1,m0,... one grant every 2 cycles; every rvalid lands on the correct master.
- Reset asserted during ACCESS of a write to 0x30 -> mem_we = 0 that cycle; no rvalid; word 0x30 unchanged; state returns to IDLE.
- With DM_ARBITER_TRACE_EN, pc=0x00003000 write 0xDEADBEEF to 0x10 -> log line "@00003000: *00000010 <= deadbeef". Without the macro, no output.
